// File: rtl/bus_rx_pkg.sv
// rtl/bus_rx_pkg.sv - shared constants and helpers for the bus receive port
// Purpose: default word width / FIFO depth and the clog2 helper used to size
//          the FIFO pointers and occupancy counter.
package bus_rx_pkg;

    localparam int BUS_RX_WIDTH_DEF = 8;
    localparam int BUS_RX_DEPTH_DEF = 2;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rx_port_if.sv
// rtl/bus_rx_port_if.sv - sender/consumer signal bundle of the bus receive port
// Purpose: groups the bus-side strobe/data, the consumer-side read/enable and
//          the status flags of bus_rx_port.
// Signals: bus, stb, busy, ovf (sender side); y, oe_, rdy, rd (consumer side);
//          clrerr (error clear); bus_par, perr only with BUS_RX_PARITY_EN.
// Modports: master drives the port (sender/consumer), slave is bus_rx_port.
interface bus_rx_port_if
    import bus_rx_pkg::*;
#(
    parameter int WIDTH = BUS_RX_WIDTH_DEF
);

    logic [WIDTH-1:0] bus;
    logic             stb;
    logic             busy;
    logic [WIDTH-1:0] y;
    logic             oe_;
    logic             rdy;
    logic             rd;
    logic             ovf;
    logic             clrerr;
`ifdef BUS_RX_PARITY_EN
    logic             bus_par;
    logic             perr;
`endif

    modport master (
        output bus, stb, oe_, rd, clrerr,
`ifdef BUS_RX_PARITY_EN
        output bus_par,
        input  perr,
`endif
        input  busy, y, rdy, ovf
    );

    modport slave (
        input  bus, stb, oe_, rd, clrerr,
`ifdef BUS_RX_PARITY_EN
        input  bus_par,
        output perr,
`endif
        output busy, y, rdy, ovf
    );

endinterface

// File: rtl/bus_rx_fifo.sv
// rtl/bus_rx_fifo.sv - DEPTH-entry word FIFO with occupancy decode
// Purpose: storage, write/read pointers and count for bus_rx_port.
// Ports: cp, clr_ (async active-low); wr_i/wdata_i write request; rd_i pop
//        request; rdata_o head word; empty_o/full_o decoded from registered
//        count; wr_ok_o accepted write; ovr_o write dropped because full.
module bus_rx_fifo
    import bus_rx_pkg::*;
#(
    parameter int WIDTH = BUS_RX_WIDTH_DEF,
    parameter int DEPTH = BUS_RX_DEPTH_DEF
) (
    input  logic             cp,
    input  logic             clr_,
    input  logic             wr_i,
    input  logic             rd_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             wr_ok_o,
    output logic             ovr_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rd_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign rdata_o = mem_q[rp_q];

    // A pop on a full FIFO frees the slot the incoming word lands in.
    assign rd_ok   = rd_i & ~empty_o;
    assign wr_ok_o = wr_i & (~full_o | rd_i);
    assign ovr_o   = wr_i & full_o & ~rd_i;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wp_d  = wr_ok_o ? wp_q + 1'b1 : wp_q;
        rp_d  = rd_ok   ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q;
        case ({wr_ok_o, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            if (wr_ok_o) begin
                mem_q[wp_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/bus_rx_port.sv
// rtl/bus_rx_port.sv - tristate register bus receive port with FIFO
// Purpose: captures strobed bus words into a FIFO, presents the head word on a
//          tristate output, and reports back-pressure and sticky errors.
// Ports: cp clock, clr_ async active-low reset, bif (bus_rx_port_if.slave):
//        bus/stb in, busy/ovf out, y/rdy out, oe_/rd in, clrerr in.
// Option: BUS_RX_PARITY_EN adds bif.bus_par and sticky bif.perr (even parity).
module bus_rx_port
    import bus_rx_pkg::*;
#(
    parameter int WIDTH = BUS_RX_WIDTH_DEF,
    parameter int DEPTH = BUS_RX_DEPTH_DEF
) (
    input  logic          cp,
    input  logic          clr_,
    bus_rx_port_if.slave  bif
);

    logic [WIDTH-1:0] head;
    logic             empty;
    logic             full;
    logic             wr_ok;
    logic             ovr;
    logic             ovf_q, ovf_d;

    bus_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .cp      (cp),
        .clr_    (clr_),
        .wr_i    (bif.stb),
        .rd_i    (bif.rd),
        .wdata_i (bif.bus),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full),
        .wr_ok_o (wr_ok),
        .ovr_o   (ovr)
    );

    // Set has priority over clear so an overrun in the clearing cycle is kept.
    always_comb begin
        ovf_d = ovf_q;
        if (ovr) begin
            ovf_d = 1'b1;
        end else if (bif.clrerr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

`ifdef BUS_RX_PARITY_EN
    logic perr_q, perr_d;
    logic par_bad;

    // Only accepted words are checked; dropped overrun words are ignored.
    assign par_bad = wr_ok & (^{bif.bus, bif.bus_par});

    always_comb begin
        perr_d = perr_q;
        if (par_bad) begin
            perr_d = 1'b1;
        end else if (bif.clrerr) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge cp or negedge clr_) begin
        if (!clr_) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bif.perr = perr_q;
`endif

    assign bif.y    = bif.oe_ ? {WIDTH{1'bz}} : head;
    assign bif.rdy  = ~empty;
    assign bif.busy = full;
    assign bif.ovf  = ovf_q;

endmodule
